// File: rtl/spram_burst_initiator_pkg.sv
// Shared types and constants for the SPRAM burst initiator and its response FIFO.
package spram_burst_initiator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RD    = 2'd1,
    ST_WR    = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam int FIFO_DEPTH = 3;
  localparam int FIFO_CW    = 2;

  // A request length of 0 means one beat; anything above the maximum is clamped.
  function automatic int len_clamp(input int len, input int max_len);
    if (len == 0) return 1;
    if (len > max_len) return max_len;
    return len;
  endfunction

endpackage

// File: rtl/spram_burst_initiator_rsp_fifo.sv
// Three-entry synchronous FIFO holding {last, data} read beats between the SPRAM
// read port and the response interface.
module spram_burst_initiator_rsp_fifo
  import spram_burst_initiator_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               push,
  input  logic [DWIDTH-1:0]  push_data,
  input  logic               push_last,
  input  logic               pop,
  output logic [DWIDTH-1:0]  head_data,
  output logic               head_last,
  output logic [FIFO_CW-1:0] count
);

  logic [DWIDTH:0]      mem [FIFO_DEPTH];
  logic [FIFO_CW-1:0]   wr_ptr;
  logic [FIFO_CW-1:0]   rd_ptr;

  function automatic logic [FIFO_CW-1:0] ptr_inc(input logic [FIFO_CW-1:0] p);
    return (p == FIFO_CW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {push_last, push_data};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_data = mem[rd_ptr][DWIDTH-1:0];
  assign head_last = mem[rd_ptr][DWIDTH];

  overflow_chk: assert property (@(posedge clk) disable iff (!resetn)
    !(push && !pop && count == FIFO_CW'(FIFO_DEPTH)));

endmodule

// File: rtl/spram_burst_initiator.sv
// Burst read/write initiator for a single-port byte-enabled SPRAM with 1-cycle read
// latency; read beats return through a small FIFO so back-pressure never drops data.
//
// state | meaning
// IDLE  | ready for a request
// RD    | issuing read addresses while the response FIFO has room
// WR    | one RAM write per accepted write beat
// DRAIN | all reads issued, waiting for the last beat to be consumed
module spram_burst_initiator
  import spram_burst_initiator_pkg::*;
#(
  parameter int AWIDTH   = 10,
  parameter int DWIDTH   = 32,
  parameter int MAXBURST = 8,
  localparam int LWIDTH  = $clog2(MAXBURST) + 1,
  localparam int BWIDTH  = DWIDTH / 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [LWIDTH-1:0] req_len,
  input  logic [BWIDTH-1:0] req_byteen,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DWIDTH-1:0] wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DWIDTH-1:0] rsp_data,
  output logic              rsp_last,
  output logic              busy,
  output logic [AWIDTH-1:0] ram_address,
  output logic              ram_wren,
  output logic [DWIDTH-1:0] ram_data,
  output logic [BWIDTH-1:0] ram_byteen,
  input  logic [DWIDTH-1:0] ram_out
);

  state_t              state, state_nxt;
  logic [AWIDTH-1:0]   addr_q;
  logic [LWIDTH-1:0]   rem_q;
  logic [LWIDTH-1:0]   len_eff;
  logic                rdi_q, rdi_last_q;
  logic                inf_q, inf_last_q;
  logic [FIFO_CW-1:0]  fifo_count;
  logic [2:0]          occ;
  logic                accept, issue, pop;

  assign len_eff = LWIDTH'(len_clamp(int'(req_len), MAXBURST));
  assign accept  = req_valid && req_ready;
  assign pop     = rsp_valid && rsp_ready;

  // Reads sit two cycles in the RAM pipe (address stage, data stage) before landing in
  // the FIFO, so both count against its space; a pop this cycle frees one slot, which is
  // what lets a burst sustain one beat per cycle with rsp_ready held high.
  assign occ   = 3'(fifo_count) + 3'(rdi_q) + 3'(inf_q) - 3'(pop);
  assign issue = (state == ST_RD) && (occ < 3'(FIFO_DEPTH));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    req_ready   = 1'b0;
    wdata_ready = 1'b0;
    ram_wren    = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_we)                      state_nxt = ST_WR;
          else if (len_eff == LWIDTH'(1))  state_nxt = ST_DRAIN;
          else                             state_nxt = ST_RD;
        end
      end
      ST_RD: begin
        if (issue && rem_q == LWIDTH'(1)) state_nxt = ST_DRAIN;
      end
      ST_WR: begin
        wdata_ready = 1'b1;
        ram_wren    = wdata_valid;
        if (wdata_valid && rem_q == LWIDTH'(1)) state_nxt = ST_IDLE;
      end
      ST_DRAIN: begin
        if (!rdi_q && !inf_q && fifo_count == '0) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Acceptance loads the first address straight onto the RAM port; for reads that
  // counts as the first issue.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ram_address <= '0;
      ram_byteen  <= '0;
      addr_q      <= '0;
      rem_q       <= '0;
      rdi_q       <= 1'b0;
      rdi_last_q  <= 1'b0;
      inf_q       <= 1'b0;
      inf_last_q  <= 1'b0;
    end else begin
      rdi_q      <= 1'b0;
      rdi_last_q <= 1'b0;
      inf_q      <= rdi_q;
      inf_last_q <= rdi_last_q;
      if (accept) begin
        ram_address <= req_addr;
        addr_q      <= req_addr + 1'b1;
        ram_byteen  <= req_byteen;
        if (req_we) begin
          rem_q <= len_eff;
        end else begin
          rem_q      <= len_eff - 1'b1;
          rdi_q      <= 1'b1;
          rdi_last_q <= (len_eff == LWIDTH'(1));
        end
      end else if (issue) begin
        ram_address <= addr_q;
        addr_q      <= addr_q + 1'b1;
        rem_q       <= rem_q - 1'b1;
        rdi_q       <= 1'b1;
        rdi_last_q  <= (rem_q == LWIDTH'(1));
      end else if (ram_wren) begin
        ram_address <= addr_q;
        addr_q      <= addr_q + 1'b1;
        rem_q       <= rem_q - 1'b1;
      end
    end
  end

  spram_burst_initiator_rsp_fifo #(.DWIDTH(DWIDTH)) u_rsp_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (inf_q),
    .push_data (ram_out),
    .push_last (inf_last_q),
    .pop       (pop),
    .head_data (rsp_data),
    .head_last (rsp_last),
    .count     (fifo_count)
  );

  assign rsp_valid = (fifo_count != '0);
  assign busy      = (state != ST_IDLE) || (fifo_count != '0);
  assign ram_data  = wdata;

endmodule
